// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared trigger frame constants and state type
package config_pkg;

    localparam logic [31:0] TRIGGER_ETHERTYPE_WORD = 32'h7274_005c;
    localparam logic [31:0] TRIGGER_MAGIC_WORD     = 32'h6e69_6769;
    localparam int          BEAT_IDX_WIDTH         = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } triggerState_e;

    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/trigger_tx_if.sv
// rtl/trigger_tx_if.sv - trigger frame transmit stream
interface trigger_tx_if;
  logic [31:0] TxTdata;
  logic [3:0]  TxTstrb;
  logic        TxTvalid;
  logic        TxTlast;
  logic        TxTready;

  modport master (output TxTdata, TxTstrb, TxTvalid, TxTlast, input TxTready);
  modport slave  (input TxTdata, TxTstrb, TxTvalid, TxTlast, output TxTready);
endinterface

// File: rtl/trigger_tx_counter.sv
// rtl/trigger_tx_counter.sv - clearable enabled up-counter
module trigger_tx_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/trigger_tx.sv
// rtl/trigger_tx.sv - trigger frame generator with request merging and gap
module trigger_tx
  import config_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'h4502_1111_6843,
  parameter logic [47:0] SRC_MAC     = 48'h8f54_0000_1654,
  parameter int          FRAME_WORDS = 15,
  parameter int          GAP_CYCLES  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                TriggerReq,
  trigger_tx_if.master        tx,
  output logic                Busy,
  output logic                FrameSent,
  output logic [7:0]          DropCount
);

  localparam logic [BEAT_IDX_WIDTH-1:0] LAST_IDX = BEAT_IDX_WIDTH'(FRAME_WORDS - 1);
  localparam logic [7:0]                GAP_LAST = 8'(GAP_CYCLES - 1);

  triggerState_e             state, nextState;
  logic [BEAT_IDX_WIDTH-1:0] beatIdx;
  logic [7:0]                gapCnt;
  logic                      pending;
  logic [31:0]               seqNum;
  logic [7:0]                dropCnt;
  logic [31:0]               beatWord;
  logic                      handshake, lastBeat, frameDone, startFrame;

  assign handshake  = (state == SEND) && tx.TxTready;
  assign lastBeat   = (beatIdx == LAST_IDX);
  assign frameDone  = handshake && lastBeat;
  assign startFrame = (state == IDLE) && (TriggerReq || pending);

  trigger_tx_counter #(.WIDTH(BEAT_IDX_WIDTH)) beatCounter (
    .clk    (clk),
    .reset  (reset),
    .clear  (frameDone),
    .enable (handshake),
    .count  (beatIdx)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startFrame) nextState = SEND;
      SEND:    if (frameDone) nextState = GAP;
      GAP:     if (gapCnt == GAP_LAST) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state != GAP || gapCnt == GAP_LAST)
      gapCnt <= 8'd0;
    else
      gapCnt <= gapCnt + 8'd1;
  end

  // A request arriving while busy is remembered once; further ones are counted as dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      dropCnt <= 8'd0;
    end else begin
      if (startFrame)
        pending <= 1'b0;
      else if (TriggerReq && state != IDLE)
        pending <= 1'b1;
      if (TriggerReq && pending && state != IDLE)
        dropCnt <= satInc8(dropCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      seqNum <= 32'd0;
    else if (frameDone)
      seqNum <= seqNum + 32'd1;
  end

  always_comb begin
    beatWord = 32'd0;
    case (beatIdx)
      5'd0:    beatWord = DST_MAC[31:0];
      5'd1:    beatWord = {SRC_MAC[15:0], DST_MAC[47:32]};
      5'd2:    beatWord = SRC_MAC[47:16];
      5'd3:    beatWord = TRIGGER_ETHERTYPE_WORD;
      5'd4:    beatWord = TRIGGER_MAGIC_WORD;
      5'd5:    beatWord = seqNum;
      default: beatWord = 32'd0;
    endcase
  end

  assign tx.TxTvalid = (state == SEND);
  assign tx.TxTdata  = (state == SEND) ? beatWord : 32'd0;
  assign tx.TxTstrb  = (state == SEND) ? 4'hF : 4'h0;
  assign tx.TxTlast  = (state == SEND) && lastBeat;
  assign Busy        = (state != IDLE);
  assign FrameSent   = frameDone;
  assign DropCount   = dropCnt;

endmodule

// File: tb/tb_trigger_tx.sv
// tb/tb_trigger_tx.sv - scoreboard bench for trigger_tx
module tb_trigger_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       triggerReq;
  logic       busy;
  logic       frameSent;
  logic [7:0] dropCount;

  trigger_tx_if txIf();

  trigger_tx dut (
    .clk        (clk),
    .reset      (reset),
    .TriggerReq (triggerReq),
    .tx         (txIf),
    .Busy       (busy),
    .FrameSent  (frameSent),
    .DropCount  (dropCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          idx;
  } beat_t;

  beat_t expQ[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    firstCyc = 0, lastCyc = 0, prevLastCyc = 0;
  int    framesSeen = 0, matchCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hdrWord(input int idx, input logic [31:0] seq);
    case (idx)
      0:       return 32'h1111_6843;
      1:       return 32'h1654_4502;
      2:       return 32'h8f54_0000;
      3:       return 32'h7274_005c;
      4:       return 32'h6e69_6769;
      5:       return seq;
      default: return 32'd0;
    endcase
  endfunction

  task automatic pushFrame(input logic [31:0] seq);
    for (int i = 0; i < 15; i++) begin
      beat_t b;
      b.data = hdrWord(i, seq);
      b.last = (i == 14);
      b.idx  = i;
      expQ.push_back(b);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDone();
    int n = 0;
    while ((expQ.size() != 0 || busy) && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_within_budget", 32'(n < 200), 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard pop, stall-hold check, and a receive-side matcher model.
  initial begin
    logic        holdValid = 1'b0;
    logic [31:0] holdData = 32'd0;
    logic        holdLast = 1'b0;
    int          rxIdx = 0;
    logic        rxOk = 1'b1;
    beat_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        holdValid = 1'b0;
        rxIdx = 0;
        rxOk = 1'b1;
      end else begin
        if (holdValid && txIf.TxTvalid) begin
          check("stall_data", txIf.TxTdata, holdData);
          check("stall_last", 32'(txIf.TxTlast), 32'(holdLast));
        end
        holdValid = txIf.TxTvalid && !txIf.TxTready;
        holdData  = txIf.TxTdata;
        holdLast  = txIf.TxTlast;
        if (txIf.TxTvalid && txIf.TxTready) begin
          if (expQ.size() == 0) begin
            check("unexpected_beat", 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            check($sformatf("beat%0d_data", e.idx), txIf.TxTdata, e.data);
            check($sformatf("beat%0d_last", e.idx), 32'(txIf.TxTlast), 32'(e.last));
            check($sformatf("beat%0d_strb", e.idx), 32'(txIf.TxTstrb), 32'hF);
            check($sformatf("beat%0d_framesent", e.idx), 32'(frameSent), 32'(e.last));
            if (e.idx == 0) firstCyc = cyc;
            if (e.last) begin
              prevLastCyc = lastCyc;
              lastCyc = cyc;
            end
          end
          if (rxIdx == 3 && txIf.TxTdata !== 32'h7274_005c) rxOk = 1'b0;
          if (rxIdx == 4 && txIf.TxTdata !== 32'h6e69_6769) rxOk = 1'b0;
          if (txIf.TxTlast) begin
            if (rxOk) matchCount++;
            rxIdx = 0;
            rxOk = 1'b1;
          end else begin
            rxIdx++;
          end
        end
        if (frameSent) framesSeen++;
      end
    end
  end

  initial begin
    int t0;
    reset = 1'b1;
    triggerReq = 1'b0;
    txIf.TxTready = 1'b1;
    tick(3);
    check("reset_valid", 32'(txIf.TxTvalid), 32'd0);
    check("reset_last", 32'(txIf.TxTlast), 32'd0);
    check("reset_framesent", 32'(frameSent), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data", txIf.TxTdata, 32'd0);
    check("reset_dropcount", 32'(dropCount), 32'd0);
    reset = 1'b0;

    // single request at relative cycle 10
    t0 = cyc;
    tick(10);
    triggerReq = 1'b1;
    pushFrame(32'd0);
    tick(1);
    triggerReq = 1'b0;
    waitDone();
    check("single_first_cycle", 32'(firstCyc - t0), 32'd11);
    check("single_last_cycle", 32'(lastCyc - t0), 32'd25);

    // backpressure: ready alternates 1/0 starting on the first valid cycle
    tick(1);
    triggerReq = 1'b1;
    txIf.TxTready = 1'b0;
    pushFrame(32'd1);
    tick(1);
    triggerReq = 1'b0;
    for (int i = 0; i < 30; i++) begin
      txIf.TxTready = (i % 2 == 0);
      tick(1);
    end
    txIf.TxTready = 1'b1;
    waitDone();
    check("bp_frame_cycles", 32'(lastCyc - firstCyc + 1), 32'd29);

    // reset while beat 7 is on the bus
    tick(1);
    triggerReq = 1'b1;
    pushFrame(32'd2);
    tick(1);
    triggerReq = 1'b0;
    tick(7);
    reset = 1'b1;
    tick(1);
    check("abort_valid", 32'(txIf.TxTvalid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", txIf.TxTdata, 32'd0);
    check("abort_last", 32'(txIf.TxTlast), 32'd0);
    expQ.delete();
    reset = 1'b0;

    // one request in SEND, two in GAP: one merged frame, two drops
    tick(1);
    triggerReq = 1'b1;
    pushFrame(32'd0);
    pushFrame(32'd1);
    tick(1);
    triggerReq = 1'b0;
    tick(4);
    triggerReq = 1'b1;
    tick(1);
    triggerReq = 1'b0;
    tick(12);
    triggerReq = 1'b1;
    tick(1);
    triggerReq = 1'b0;
    tick(1);
    triggerReq = 1'b1;
    tick(1);
    triggerReq = 1'b0;
    waitDone();
    check("merge_dropcount", 32'(dropCount), 32'd2);
    check("merge_spacing_ge17", 32'((firstCyc - prevLastCyc) >= 17), 32'd1);
    tick(40);
    check("merge_frames_total", 32'(framesSeen), 32'd4);

    // sequence number wrap
    force dut.seqNum = 32'hFFFF_FFFF;
    tick(1);
    release dut.seqNum;
    triggerReq = 1'b1;
    pushFrame(32'hFFFF_FFFF);
    tick(1);
    triggerReq = 1'b0;
    waitDone();
    triggerReq = 1'b1;
    pushFrame(32'd0);
    tick(1);
    triggerReq = 1'b0;
    waitDone();

    // held request under long stall saturates the drop counter
    triggerReq = 1'b1;
    txIf.TxTready = 1'b0;
    pushFrame(32'd1);
    pushFrame(32'd2);
    tick(300);
    check("sat_dropcount", 32'(dropCount), 32'hFF);
    check("sat_busy", 32'(busy), 32'd1);
    check("sat_held_beat0", txIf.TxTdata, 32'h1111_6843);
    triggerReq = 1'b0;
    txIf.TxTready = 1'b1;
    waitDone();
    tick(5);
    check("sat_dropcount_after", 32'(dropCount), 32'hFF);
    check("frames_total", 32'(framesSeen), 32'd8);
    check("matcher_hits", 32'(matchCount), 32'd8);
    check("queue_empty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trigger_tx.md
TRIGGER_TX -- requirements
Module: trigger_tx

Interface
REQ-001 SHALL have parameter DST_MAC, default 48'h4502_1111_6843, destination MAC of the trigger frame.
REQ-002 SHALL have parameter SRC_MAC, default 48'h8f54_0000_1654, source MAC of the trigger frame.
REQ-003 SHALL have parameter FRAME_WORDS, default 15, total 32-bit beats per frame (legal range 6..31).
REQ-004 SHALL have parameter GAP_CYCLES, default 16, minimum idle cycles after a frame (legal range 1..255).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 TriggerReq  input  1  request to send one trigger frame; sampled every cycle.
REQ-008 TxTdata  output  32  frame beat data.
REQ-009 TxTstrb  output  4  byte strobes.
REQ-010 TxTvalid  output  1  beat valid.
REQ-011 TxTlast  output  1  last beat of frame.
REQ-012 TxTready  input  1  sink accepts beat.
REQ-013 Busy  output  1  high whenever state is not IDLE.
REQ-014 FrameSent  output  1  one-cycle pulse on acceptance of the last beat.
REQ-015 DropCount  output  8  saturating count of merged/dropped requests.

Function
REQ-016 States IDLE, SEND, GAP; IDLE->SEND when TriggerReq|Pending; SEND->GAP on last-beat handshake; GAP->IDLE after GAP_CYCLES cycles in GAP.
REQ-017 TxTvalid SHALL equal (state==SEND); from TriggerReq high in IDLE at cycle N, TxTvalid is high at N+1 with beat 0.
REQ-018 Handshake = TxTvalid & TxTready; beat index advances only on handshake; TxTdata/TxTlast stable while TxTvalid & !TxTready.
REQ-019 Beat map: 0 = DST_MAC[31:0]; 1 = {SRC_MAC[15:0], DST_MAC[47:32]}; 2 = SRC_MAC[47:16]; 3 = 32'h7274_005c; 4 = 32'h6e69_6769; 5 = SeqNum; 6..FRAME_WORDS-1 = 0.
REQ-020 TxTstrb SHALL be 4'hF on every beat; TxTlast high only on beat FRAME_WORDS-1.
REQ-021 SeqNum 32-bit, SHALL increment by 1 on each FrameSent, wrapping 32'hFFFF_FFFF->0; the value sent is the pre-increment value.
REQ-022 Pending SHALL set on TriggerReq while state is SEND or GAP, and clear on the IDLE->SEND transition.
REQ-023 TriggerReq while Pending already set and state is not IDLE SHALL increment DropCount, saturating at 8'hFF.
REQ-024 TriggerReq in the same cycle as IDLE->SEND SHALL NOT set Pending (consumed by that frame).
REQ-025 Minimum spacing from last-beat handshake to next beat-0 TxTvalid SHALL be GAP_CYCLES+1 cycles.
REQ-026 TxTready low for any number of cycles SHALL stall without data loss or state change.

Reset
REQ-027 On reset: state IDLE, beat index 0, Pending 0, SeqNum 0, DropCount 0, GAP counter 0.
REQ-028 During reset: TxTvalid 0, TxTlast 0, FrameSent 0, Busy 0, TxTdata 0.
REQ-029 Reset mid-frame SHALL abort the frame; next frame restarts at beat 0 with SeqNum 0.

Structure
REQ-030 Constants TRIGGER_ETHERTYPE_WORD (32'h7274_005c) and TRIGGER_MAGIC_WORD (32'h6e69_6769) and the state typedef SHALL live in config_pkg, shared with the receive-side trigger matcher.
REQ-031 Beat index SHALL use the existing counter sub-module (width 5), reset by reset or frame completion, enabled by handshake.

Verification
REQ-032 Single req, TxTready=1: pulse TriggerReq at cycle 10 -> beats 11..25, beat0 32'h1111_6843, beat1 32'h1654_4502, beat5 0, TxTlast at 25, FrameSent at 25.
REQ-033 Backpressure: TxTready toggled 1/0 per cycle -> identical 15-beat sequence, data held during stalls, 29 cycles total.
REQ-034 Req during SEND plus two more during GAP -> exactly one more frame, beat5 = 1, DropCount = 2, spacing >= 17 cycles.
REQ-035 SeqNum wrap: force SeqNum 32'hFFFF_FFFF via 2^32-frame-equivalent preload in bench -> beat5 32'hFFFF_FFFF, next frame beat5 0.
REQ-036 Reset asserted at beat 7 -> TxTvalid 0 next cycle; subsequent req yields full frame from beat 0, beat5 = 0.
REQ-037 Loopback into receive-side trigger matcher -> matcher trigger asserts once per frame sent.
